// File: rtl/neuron_mac_pkg.sv
// Shared fixed-point constants and saturation helpers for the NAR network datapath.
// Accumulator, tanh lookup and neuron blocks all clamp through these functions.
package neuron_mac_pkg;

    localparam int N_DEF = 10;
    localparam int Q_DEF = 9;

    // Helpers work on a wide signed carrier so any word width up to 32 bits can share them.
    localparam int WIDE_W = 64;

    function automatic logic signed [WIDE_W-1:0] sat_max(input int n);
        return (64'sd1 <<< (n - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [WIDE_W-1:0] sat_min(input int n);
        return -(64'sd1 <<< (n - 1));
    endfunction

    function automatic logic signed [WIDE_W-1:0] saturate(input logic signed [WIDE_W-1:0] v,
                                                          input int n);
        logic signed [WIDE_W-1:0] r;
        r = v;
        if (v > sat_max(n)) begin
            r = sat_max(n);
        end else if (v < sat_min(n)) begin
            r = sat_min(n);
        end
        return r;
    endfunction

    localparam logic signed [N_DEF-1:0] SAT_MAX_DEF = N_DEF'(sat_max(N_DEF));
    localparam logic signed [N_DEF-1:0] SAT_MIN_DEF = N_DEF'(sat_min(N_DEF));

endpackage

// File: rtl/neuron_mac_if.sv
// Weight/input/bias stream into one neuron and its pre-activation result back to the controller.
interface neuron_mac_if
    import neuron_mac_pkg::*;
#(
    parameter int N = N_DEF
) ();

    logic                inptReady;
    logic signed [N-1:0] w;
    logic signed [N-1:0] x;
    logic signed [N-1:0] b;
    logic signed [N-1:0] out;
    logic                outReady;

    modport master (
        output inptReady, w, x, b,
        input  out, outReady
    );

    modport slave (
        input  inptReady, w, x, b,
        output out, outReady
    );

endinterface

// File: rtl/neuron_mac_mul.sv
// Fixed-point multiply: full-width signed product, floor shift by Q, clamp to N bits.
module fxp_mul_sat
    import neuron_mac_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int Q = Q_DEF
) (
    input  logic signed [N-1:0] i_a,
    input  logic signed [N-1:0] i_b,
    output logic signed [N-1:0] o_p
);

    logic signed [2*N-1:0] w_full;
    logic signed [2*N-1:0] w_shift;

    assign w_full  = i_a * i_b;
    // Arithmetic shift floors toward -inf, so tiny negative products become -1, not 0.
    assign w_shift = w_full >>> Q;
    assign o_p     = N'(saturate(64'(w_shift), N));

endmodule

// File: rtl/neuron_mac.sv
// Single fixed-point neuron: saturating sum of w*x products plus a combinational bias.
// State is only the accumulator and the one-cycle result strobe.
module neuron_mac
    import neuron_mac_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int Q = Q_DEF
) (
    input  logic         clk,
    input  logic         rst,
    neuron_mac_if.slave  bus
);

    logic signed [N-1:0] w_prod;
    logic signed [N:0]   w_acc_sum;
    logic signed [N-1:0] w_acc_next;
    logic signed [N:0]   w_out_sum;

    logic signed [N-1:0] r_acc;
    logic                r_out_ready;

    fxp_mul_sat #(
        .N (N),
        .Q (Q)
    ) u_mul (
        .i_a (bus.w),
        .i_b (bus.x),
        .o_p (w_prod)
    );

    // One guard bit is enough: two in-range N-bit values cannot overflow N+1 bits.
    assign w_acc_sum  = {r_acc[N-1], r_acc} + {w_prod[N-1], w_prod};
    assign w_acc_next = N'(saturate(64'(w_acc_sum), N));

    // The accumulator only loads when inptReady is high, so junk on w/x while idle never reaches it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_out_ready <= 1'b0;
        end else begin
            r_out_ready <= bus.inptReady;
            if (bus.inptReady) begin
                r_acc <= w_acc_next;
            end
        end
    end

    // Bias is added after the register so a bias change shows up in the same cycle.
    assign w_out_sum    = {r_acc[N-1], r_acc} + {bus.b[N-1], bus.b};
    assign bus.out      = N'(saturate(64'(w_out_sum), N));
    assign bus.outReady = r_out_ready;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed check of neuron_mac: table of single-cycle vectors, then hand sequences
// for mid-cycle bias changes and asynchronous reset.
module tb_neuron_mac;

    localparam int N = 10;
    localparam int Q = 9;

    typedef struct {
        string name;
        bit    do_rst;
        bit    ir;
        int    w;
        int    x;
        int    b;
        int    exp_out;
        bit    exp_rdy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    neuron_mac_if #(.N(N)) bus ();

    neuron_mac #(
        .N (N),
        .Q (Q)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input bit do_rst, input bit ir, input int w, input int x,
                       input int b, input int exp_out, input bit exp_rdy);
        vec_t v;
        v.name = nm; v.do_rst = do_rst; v.ir = ir; v.w = w; v.x = x; v.b = b;
        v.exp_out = exp_out; v.exp_rdy = exp_rdy;
        vecs.push_back(v);
    endtask

    task automatic drive(input bit ir, input int w, input int x, input int b);
        bus.inptReady = ir;
        bus.w = N'(w);
        bus.x = N'(x);
        bus.b = N'(b);
    endtask

    // Pulse reset between edges and confirm the cleared state shows through immediately.
    task automatic pulse_reset(input string nm, input int b);
        bus.b = N'(b);
        rst = 1'b1;
        #1;
        check({nm, "_rst_out"}, int'(bus.out), b);
        check({nm, "_rst_rdy"}, int'(bus.outReady), 0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("init_out", int'(bus.out), 0);
        check("init_rdy", int'(bus.outReady), 0);
        @(negedge clk);
        rst = 1'b0;

        // name, rst, ir, w, x, b, out, rdy
        add("basic_mac",     1, 1,  256,  256,   64,  192, 1);
        add("basic_drop",    0, 0,    0,    0,   64,  192, 0);
        add("stream_1",      1, 1,  128,  256,    0,   64, 1);
        add("stream_2",      0, 1,  128,  256,    0,  128, 1);
        add("stream_3",      0, 1,  128,  256,    0,  192, 1);
        add("stream_4",      0, 1,  128,  256,    0,  256, 1);
        add("stream_idle",   0, 0,    5,    7,    0,  256, 0);
        add("sat_1",         1, 1, -512, -512,    0,  511, 1);
        add("sat_2",         0, 1, -512, -512,    0,  511, 1);
        add("sat_3",         0, 1, -512, -512,    0,  511, 1);
        add("sat_4",         0, 1, -512, -512,    0,  511, 1);
        add("sat_back",      0, 1, -512,  256,    0,  255, 1);
        add("idle_garbage",  0, 0, -512, -512,    0,  255, 0);
        add("floor_pos",     1, 1,    1,    1,    0,    0, 1);
        add("floor_neg",     1, 1,   -1,    1,    0,   -1, 1);
        add("bias_min",      0, 0,    0,    0, -512, -512, 0);
        add("neg_sat_1",     1, 1,  511, -512,    0, -511, 1);
        add("neg_sat_2",     0, 1,  511, -512,    0, -512, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            if (vecs[i].do_rst) pulse_reset(vecs[i].name, vecs[i].b);
            drive(vecs[i].ir, vecs[i].w, vecs[i].x, vecs[i].b);
            @(posedge clk);
            #1;
            $display("vec %0d %s: ir=%0d w=%0d x=%0d b=%0d -> out=%0d rdy=%0d", i, vecs[i].name,
                     vecs[i].ir, vecs[i].w, vecs[i].x, vecs[i].b, bus.out, bus.outReady);
            check({vecs[i].name, "_out"}, int'(bus.out), vecs[i].exp_out);
            check({vecs[i].name, "_rdy"}, int'(bus.outReady), int'(vecs[i].exp_rdy));
        end

        // Bias path is combinational: mid-cycle changes appear without a clock edge.
        @(negedge clk);
        pulse_reset("bias", 0);
        drive(1, 200, 256, 0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0);
        check("bias_acc100", int'(bus.out), 100);
        #2;
        bus.b = 10'sd200;
        #1;
        check("bias_200", int'(bus.out), 300);
        bus.b = 10'sd500;
        #1;
        check("bias_500", int'(bus.out), 511);
        $display("seq bias: acc=100 b=0/200/500 -> out=%0d", bus.out);

        // Build acc=300, then reset between edges with outReady still high.
        @(negedge clk);
        drive(1, 400, 256, 0);
        @(posedge clk);
        #1;
        check("areset_acc300", int'(bus.out), 300);
        check("areset_rdy_pre", int'(bus.outReady), 1);
        #1;
        bus.b = 10'sd7;
        rst = 1'b1;
        #1;
        check("areset_out", int'(bus.out), 7);
        check("areset_rdy", int'(bus.outReady), 0);
        // Reset held across an inptReady edge: reset wins.
        drive(1, 256, 256, 7);
        @(posedge clk);
        #1;
        check("areset_edge_out", int'(bus.out), 7);
        check("areset_edge_rdy", int'(bus.outReady), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_out", int'(bus.out), 135);
        check("post_rst_rdy", int'(bus.outReady), 1);
        $display("seq async reset: after release out=%0d rdy=%0d", bus.out, bus.outReady);
        @(negedge clk);
        drive(0, 0, 0, 7);
        @(posedge clk);
        #1;
        check("post_rst_drop", int'(bus.outReady), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Single fixed-point neuron for the NAR network datapath.
- Accumulates a saturating sum of weight × input products, one product per cycle on `inptReady`, and adds a bias term.
- One instance per hidden/output neuron. A controller streams weights and inputs serially, then reads `out` (pre-activation) for the tanh lookup or for the final accumulator.
- The accumulator and tanh lookup are separate blocks and out of scope here.

Parameters:
- N, 10: total signed word width (two's complement).
- Q, 9: fractional bits. Representable range is [-2^(N-1-Q), 2^(N-1-Q) - 2^-Q]; with the defaults, [-1.0, +0.998].

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset. Clears the running sum and `outReady`; while held high, the neuron stays cleared.
- inptReady, input, 1: when high at a clock edge, accumulate w*x. Multi-cycle assertion accumulates once per cycle.
- w, input, N signed: weight, Q fractional bits.
- x, input, N signed: input sample, Q fractional bits.
- b, input, N signed: bias. Used combinationally; may change at any time.
- out, output, N signed: sat(acc + b), combinational from the acc register and port b.
- outReady, output, 1: registered. High for the cycle after each edge at which inptReady was sampled high.

Behaviour:
- Reset (async, rst=1): acc = 0, outReady = 0. Therefore out = b.
- Product: p_full = w * x, full 2N-bit signed. Arithmetic shift right by Q (floor toward -inf, no rounding). Then saturate to N bits: above MAX = 2^(N-1)-1 gives MAX; below MIN = -2^(N-1) gives MIN.
- Accumulate at a rising edge with inptReady=1 and rst=0: acc <= sat(acc + p), summed at N+1 bits then clamped to [MIN, MAX].
- inptReady=0: acc holds.
- out: sat(acc + b) at N+1 bits, clamped. Purely combinational, so a bias change is visible the same cycle.
- Latency: a product is reflected in out one clock after its inptReady edge; outReady rises at that same edge.
- No state machine. State is only the acc register and the outReady flop.
- rst asserted mid-accumulation: immediate clear regardless of clk; partial sum is discarded. A simultaneous rst and inptReady: reset wins.
- After rst deasserts, the first inptReady edge accumulates normally. No extra wait cycle is required.
- Saturation is sticky only through arithmetic. A later opposite-sign product may pull the sum back from MAX/MIN; there is no overflow flag.
- X/Z on w/x/b while inptReady=0 must not corrupt acc.

Decomposition:
- Shared package (narnet_pkg): default N and Q, and functions/constants for SAT_MAX/SAT_MIN and saturate(N+1 → N).
- The accumulator and tanh_lut blocks reuse the same saturation helpers.
- One natural sub-module: fxp_mul_sat (N, Q). Combinational w*x, then >>>Q, then saturate to N. Reusable by other datapath blocks.

Test Plan:
- Basic MAC: rst pulse; b=64 (0.125); one inptReady cycle with w=256, x=256 (0.5×0.5). Next cycle: out=192, outReady=1 for exactly one cycle.
- Multi-cycle stream: b=0; inptReady held 4 cycles with w=128, x=256 (0.25×0.5 → 64 each). out=64, 128, 192, 256 on successive cycles. outReady high for 4 cycles, low after.
- Saturation:
  - w=-512, x=-512 gives product +1.0, so out=511.
  - Three more such cycles: out stays 511.
  - Then w=-512, x=256 (-256): out=255.
- Negative floor/truncation:
  - w=1, x=1 gives out=0.
  - After rst, w=-1, x=1 gives out=-1.
  - With b=-512 and acc=-1: out=-512 (clamped).
- Bias combinational: acc=100; change b from 0 to 200 mid-cycle, out=300 immediately. Then b=500, out=511.
- Async reset mid-operation: acc=300; assert rst between clock edges, out=b and outReady=0 before the next edge. A simultaneous rst and inptReady edge: acc stays 0.
